// File: rtl/lrclk_edge_strobe_pkg.sv
// Shared types for the LRCLK edge strobe block.
//   frame_cnt_t     : width of the frame counter output
//   edge_kind_e     : classification of one synchronized sample pair
//   classify_edge() : maps (current, previous) synchronized level to an edge kind
package lrclk_edge_strobe_pkg;

  localparam int FRAME_W = 16;

  typedef logic [FRAME_W-1:0] frame_cnt_t;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10
  } edge_kind_e;

  function automatic edge_kind_e classify_edge(input logic cur, input logic prev);
    edge_kind_e kind;
    kind = EDGE_NONE;
    if (cur && !prev) begin
      kind = EDGE_RISE;
    end else if (!cur && prev) begin
      kind = EDGE_FALL;
    end
    return kind;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// N-flop single-bit synchronizer with asynchronous active-high reset.
//   clk   : destination clock
//   reset : asynchronous, active-high; clears every stage to 0
//   d     : asynchronous input bit
//   q     : synchronized output (last stage)
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;

  if (STAGES == 1) begin : g_single
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        chain_q <= '0;
      end else begin
        chain_q <= d;
      end
    end
  end else begin : g_chain
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        chain_q <= '0;
      end else begin
        chain_q <= {chain_q[STAGES-2:0], d};
      end
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/lrclk_edge_strobe.sv
// Edge detector and frame strobe for a slow external audio clock (LRCLK).
// Synchronizes test_clk into the clk domain, emits one-cycle edge pulses,
// groups counted edges into frames and watches for a stopped clock.
//   clk          : system clock
//   reset        : asynchronous, active-high
//   test_clk     : asynchronous external clock being monitored
//   rising_edge  : one-cycle pulse per synchronized 0->1 transition
//   falling_edge : one-cycle pulse per synchronized 1->0 transition
//   any_edge     : rising_edge | falling_edge
//   sample_ready : registered one-cycle strobe per completed frame
//   frame_count  : sample_ready pulses since reset, wraps at 16 bits
//   clock_lost   : high while no edge has been seen for TIMEOUT_CYCLES cycles
module lrclk_edge_strobe
  import lrclk_edge_strobe_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int EDGES_PER_FRAME = 2,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       test_clk,
  output logic       rising_edge,
  output logic       falling_edge,
  output logic       any_edge,
  output logic       sample_ready,
  output frame_cnt_t frame_count,
  output logic       clock_lost
);

  localparam int EDGE_W = $clog2(EDGES_PER_FRAME + 1);
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(EDGES_PER_FRAME - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  function automatic logic [IDLE_W-1:0] sat_inc_idle(input logic [IDLE_W-1:0] v);
    logic [IDLE_W-1:0] r;
    r = v;
    if (v != IDLE_MAX) begin
      r = v + IDLE_W'(1);
    end
    return r;
  endfunction

  logic              sync_q;
  logic              prev_q;
  logic              armed_q;
  logic [EDGE_W-1:0] edge_cnt_q;
  logic [IDLE_W-1:0] idle_cnt_q;
  edge_kind_e        edge_kind;

  // Stage: synchronizer
  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (test_clk),
    .q    (sync_q)
  );

  // Stage: edge compare (combinational from sync_q / prev_q flops)
  assign edge_kind    = classify_edge(sync_q, prev_q);
  assign rising_edge  = (edge_kind == EDGE_RISE);
  assign falling_edge = (edge_kind == EDGE_FALL);
  assign any_edge     = rising_edge | falling_edge;

  // The watchdog is saturated exactly when the clock counts as lost.
  assign clock_lost = (idle_cnt_q == IDLE_MAX);

  // Stage: arming, frame counting, watchdog
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q       <= 1'b0;
      armed_q      <= 1'b0;
      edge_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      sample_ready <= 1'b0;
      frame_count  <= '0;
    end else begin
      prev_q       <= sync_q;
      sample_ready <= 1'b0;
      idle_cnt_q   <= any_edge ? '0 : sat_inc_idle(idle_cnt_q);

      // An edge takes priority over a timeout expiring in the same cycle.
      if (any_edge) begin
        if (!armed_q) begin
          // First edge after reset or after a lost clock only arms.
          armed_q <= 1'b1;
        end else if (edge_cnt_q == EDGE_LAST) begin
          edge_cnt_q   <= '0;
          sample_ready <= 1'b1;
          frame_count  <= frame_count + FRAME_W'(1);
        end else begin
          edge_cnt_q <= edge_cnt_q + EDGE_W'(1);
        end
      end else if (idle_cnt_q == IDLE_LAST) begin
        // Watchdog is about to saturate: drop the partial frame.
        armed_q    <= 1'b0;
        edge_cnt_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lrclk_edge_strobe.sv
`timescale 1ns/1ps
module tb_lrclk_edge_strobe;

  localparam int NI = 2;
  localparam int S0 = 2, E0 = 2, T0 = 64;
  localparam int S1 = 3, E1 = 4, T1 = 40;

  logic clk      = 1'b0;
  logic reset    = 1'b1;
  logic test_clk = 1'b0;

  logic        rise [NI];
  logic        fall [NI];
  logic        anye [NI];
  logic        sr   [NI];
  logic        lost [NI];
  logic [15:0] fc   [NI];

  always #5 clk = ~clk;

  lrclk_edge_strobe #(
    .SYNC_STAGES(S0), .EDGES_PER_FRAME(E0), .TIMEOUT_CYCLES(T0)
  ) u_dut_a (
    .clk(clk), .reset(reset), .test_clk(test_clk),
    .rising_edge(rise[0]), .falling_edge(fall[0]), .any_edge(anye[0]),
    .sample_ready(sr[0]), .frame_count(fc[0]), .clock_lost(lost[0])
  );

  lrclk_edge_strobe #(
    .SYNC_STAGES(S1), .EDGES_PER_FRAME(E1), .TIMEOUT_CYCLES(T1)
  ) u_dut_b (
    .clk(clk), .reset(reset), .test_clk(test_clk),
    .rising_edge(rise[1]), .falling_edge(fall[1]), .any_edge(anye[1]),
    .sample_ready(sr[1]), .frame_count(fc[1]), .clock_lost(lost[1])
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int p_s(input int i); return (i == 0) ? S0 : S1; endfunction
  function automatic int p_e(input int i); return (i == 0) ? E0 : E1; endfunction
  function automatic int p_t(input int i); return (i == 0) ? T0 : T1; endfunction

  // Reference model: history of test_clk as sampled at each clk edge since
  // reset release (index 0 stands for the cleared synchronizer). Edges are
  // level changes of the delayed history; an edge counts toward a frame only
  // if the previous edge since reset is at most TIMEOUT cycles earlier.
  bit hist[$];
  int cyc;
  bit chk_en = 1'b0;
  int run_n [NI];
  int last_e [NI];
  bit have_prev [NI];
  bit pend [NI];
  int frames [NI];
  bit e_rise [NI];
  bit e_fall [NI];
  bit e_sr [NI];
  bit e_lost [NI];
  int e_fc [NI];

  task automatic model_reset();
    hist.delete();
    hist.push_back(1'b0);
    cyc = 0;
    for (int i = 0; i < NI; i++) begin
      run_n[i] = 0; last_e[i] = 0; have_prev[i] = 1'b0;
      pend[i] = 1'b0; frames[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    int s;
    int ref_e;
    bit sy;
    bit pv;
    s  = p_s(i);
    sy = (cyc - s + 1 >= 0) ? hist[cyc - s + 1] : 1'b0;
    pv = (cyc - s >= 0) ? hist[cyc - s] : 1'b0;
    e_rise[i] = sy & ~pv;
    e_fall[i] = ~sy & pv;
    e_sr[i]   = pend[i];
    if (pend[i]) frames[i] = (frames[i] + 1) % 65536;
    e_fc[i]   = frames[i];
    pend[i]   = 1'b0;
    ref_e     = have_prev[i] ? last_e[i] : -1;
    e_lost[i] = (cyc - ref_e) > p_t(i);
    if (sy != pv) begin
      if (have_prev[i] && (cyc - last_e[i]) <= p_t(i)) begin
        run_n[i]++;
        if (run_n[i] % p_e(i) == 0) pend[i] = 1'b1;
      end else begin
        run_n[i] = 0;
      end
      have_prev[i] = 1'b1;
      last_e[i]    = cyc;
    end
  endtask

  always @(posedge clk) begin
    if (!reset && chk_en) begin
      cyc++;
      hist.push_back(test_clk);
      for (int i = 0; i < NI; i++) model_step(i);
      #1;
      for (int i = 0; i < NI; i++) begin
        check($sformatf("rise%0d", i), int'(rise[i]), int'(e_rise[i]));
        check($sformatf("fall%0d", i), int'(fall[i]), int'(e_fall[i]));
        check($sformatf("any%0d", i),  int'(anye[i]), int'(e_rise[i] | e_fall[i]));
        check($sformatf("sr%0d", i),   int'(sr[i]),   int'(e_sr[i]));
        check($sformatf("fc%0d", i),   int'(fc[i]),   e_fc[i]);
        check($sformatf("lost%0d", i), int'(lost[i]), int'(e_lost[i]));
      end
    end
  end

  task automatic apply_reset(input bit tc);
    @(posedge clk);
    #2;
    reset  = 1'b1;
    chk_en = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_rise%0d", i), int'(rise[i]), 0);
      check($sformatf("rst_fall%0d", i), int'(fall[i]), 0);
      check($sformatf("rst_any%0d", i),  int'(anye[i]), 0);
      check($sformatf("rst_sr%0d", i),   int'(sr[i]),   0);
      check($sformatf("rst_fc%0d", i),   int'(fc[i]),   0);
      check($sformatf("rst_lost%0d", i), int'(lost[i]), 0);
    end
    test_clk = tc;
    repeat (3) @(negedge clk);
    model_reset();
    reset  = 1'b0;
    chk_en = 1'b1;
  endtask

  // Toggle test_clk (at a negedge) and hold for gap clk cycles.
  task automatic toggle_gap(input int gap);
    test_clk = ~test_clk;
    repeat (gap) @(negedge clk);
  endtask

  int fa_a [6] = '{0, 0, 1, 1, 2, 2};
  int fb_a [6] = '{0, 0, 0, 0, 1, 1};
  int fa_r [5] = '{3, 3, 4, 4, 5};
  int fb_r [5] = '{1, 1, 1, 1, 2};
  int fa_c [4] = '{5, 6, 6, 7};
  int quiet [NI];
  int lost_at [NI];
  int first_r [NI];
  bit lost_seen;
  int gap;
  int r;

  initial begin
    // Reset with test_clk low, then regular toggling every 20 cycles.
    apply_reset(1'b0);
    repeat (10) @(negedge clk);
    for (int n = 0; n < 6; n++) begin
      test_clk = ~test_clk;
      for (int j = 1; j <= 20; j++) begin
        @(posedge clk); #1;
        if (n == 0 && j == 1) check("lat_a_early", int'(rise[0]), 0);
        if (n == 0 && j == 2) begin
          check("lat_a", int'(rise[0]), 1);
          check("lat_b_early", int'(rise[1]), 0);
        end
        if (n == 0 && j == 3) check("lat_b", int'(rise[1]), 1);
        if (j == 6) begin
          check("run_fc_a", int'(fc[0]), fa_a[n]);
          check("run_model_a", frames[0], fa_a[n]);
          check("run_fc_b", int'(fc[1]), fb_a[n]);
        end
      end
      @(negedge clk);
    end

    // Seventh edge, then stop: measure edge-free cycles until clock_lost.
    for (int i = 0; i < NI; i++) begin quiet[i] = 0; lost_at[i] = -1; end
    test_clk = ~test_clk;
    for (int j = 1; j <= 300; j++) begin
      @(posedge clk); #1;
      if (j == 6) begin
        check("run_fc_a7", int'(fc[0]), 3);
        check("run_model_a7", frames[0], 3);
      end
      for (int i = 0; i < NI; i++) begin
        if (lost_at[i] < 0) begin
          if (lost[i]) lost_at[i] = quiet[i];
          else if (anye[i]) quiet[i] = 0;
          else quiet[i]++;
        end
      end
    end
    check("timeout_a", lost_at[0], T0);
    check("timeout_b", lost_at[1], T1);
    @(negedge clk);

    // Resume: first edge clears clock_lost and only arms.
    for (int n = 0; n < 5; n++) begin
      toggle_gap(20);
      check("resume_lost_a", int'(lost[0]), 0);
      check("resume_lost_b", int'(lost[1]), 0);
      check("resume_fc_a", int'(fc[0]), fa_r[n]);
      check("resume_fc_b", int'(fc[1]), fb_r[n]);
    end

    // Edges exactly TIMEOUT apart on instance a: the edge wins each time.
    lost_seen = 1'b0;
    for (int n = 0; n < 4; n++) begin
      test_clk = ~test_clk;
      for (int j = 0; j < T0; j++) begin
        @(negedge clk);
        if (lost[0]) lost_seen = 1'b1;
      end
      check("edgewin_fc_a", int'(fc[0]), fa_c[n]);
      check("edgewin_lost_b", int'(lost[1]), 1);
      check("edgewin_fc_b", int'(fc[1]), 2);
    end
    check("edgewin_nolost_a", int'(lost_seen), 0);

    // One counted edge into a frame, then reset mid-frame with test_clk high.
    toggle_gap(20);
    apply_reset(1'b1);
    for (int i = 0; i < NI; i++) first_r[i] = -1;
    for (int j = 1; j <= 10; j++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NI; i++)
        if (rise[i] && first_r[i] < 0) first_r[i] = j;
    end
    check("hi_rel_a", first_r[0], S0);
    check("hi_rel_b", first_r[1], S1);
    @(negedge clk);
    toggle_gap(20);
    check("hi_rel_fc1", int'(fc[0]), 0);
    toggle_gap(20);
    check("hi_rel_fc2", int'(fc[0]), 1);

    // Random gaps, biased toward the timeout boundaries.
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: gap = T0;
        1: gap = T0 + 1;
        2: gap = T1;
        3: gap = T1 + 1;
        default: gap = $urandom_range(3, 30);
      endcase
      toggle_gap(gap);
    end
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
